// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, state/owner types and small helpers for
// the byte-serial memory controller.
//   ADDR_WIDTH / DATA_WIDTH : request address and data widths
//   IO_SEL_HI/LO, IO_SEL    : address field that selects the IO region
package mem_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam int         IO_SEL_HI = 17;
  localparam int         IO_SEL_LO = 16;
  localparam logic [1:0] IO_SEL    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic {
    OWN_LSB,
    OWN_IF
  } owner_t;

  // Only 1 and 2 are honoured as narrow widths; anything else is a word.
  function automatic logic [2:0] width_to_len(input logic [2:0] w);
    case (w)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
    return a[IO_SEL_HI:IO_SEL_LO] == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the two requester channels (LSB, IF), the flush and
// the byte-wide RAM/IO port.
//   master : requester/RAM side (drives requests, mispredict, mem_din, io_buffer_full)
//   slave  : controller side (drives ok/data returns and the RAM bus)
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                  enable_from_lsb;
  logic                  read_or_write_from_lsb;
  logic [ADDR_WIDTH-1:0] addr_from_lsb;
  logic [DATA_WIDTH-1:0] data_from_lsb;
  logic [2:0]            width_from_lsb;
  logic                  ok_to_lsb;
  logic [DATA_WIDTH-1:0] data_to_lsb;

  logic                  enable_from_if;
  logic [ADDR_WIDTH-1:0] addr_from_if;
  logic                  ok_to_if;
  logic [DATA_WIDTH-1:0] inst_to_if;

  logic                  mispredict;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport master (
    output enable_from_lsb, read_or_write_from_lsb, addr_from_lsb,
           data_from_lsb, width_from_lsb, enable_from_if, addr_from_if,
           mispredict, mem_din, io_buffer_full,
    input  ok_to_lsb, data_to_lsb, ok_to_if, inst_to_if,
           mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  enable_from_lsb, read_or_write_from_lsb, addr_from_lsb,
           data_from_lsb, width_from_lsb, enable_from_if, addr_from_if,
           mispredict, mem_din, io_buffer_full,
    output ok_to_lsb, data_to_lsb, ok_to_if, inst_to_if,
           mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves one LSB or IF request at a time over a byte-wide RAM
// port, splitting it into byte transactions and reassembling read data
// little-endian. LSB has priority over IF.
//   clk, rst : clock, synchronous active-high reset
//   rdy      : global ready, low freezes every register
//   bus      : mem_ctrl_if.slave (requests, returns, RAM bus)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | arbitrate and accept a request, presenting byte 0
// ST_READ  | present byte addresses, capture bytes two edges later
// ST_WRITE | present address/data with mem_wr=1, stall on full IO buffer
// ST_DONE  | ok pulse high for one cycle, enables ignored
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);

  state_t                state, state_nxt;
  owner_t                owner, owner_nxt;
  logic                  rw_q, rw_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [2:0]            len_q, len_nxt;
  logic [2:0]            sent, sent_nxt;
  logic [2:0]            got, got_nxt;
  // rd_pipe[1] marks an edge whose mem_din belongs to the oldest
  // outstanding address (RAM answers one edge after it samples mem_a).
  logic [1:0]            rd_pipe, pipe_nxt;
  logic [DATA_WIDTH-1:0] buf_q, buf_nxt;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_nxt;
  logic [7:0]            dout_q, dout_nxt;
  logic                  wr_q, wr_nxt;
  logic                  ok_lsb_q, ok_lsb_nxt;
  logic                  ok_if_q, ok_if_nxt;
  logic [DATA_WIDTH-1:0] data_lsb_q, data_lsb_nxt;
  logic [DATA_WIDTH-1:0] inst_q, inst_nxt;

  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [7:0]            store_byte;
  logic [DATA_WIDTH-1:0] read_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_LSB;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      len_q      <= '0;
      sent       <= '0;
      got        <= '0;
      rd_pipe    <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      ok_lsb_q   <= 1'b0;
      ok_if_q    <= 1'b0;
      data_lsb_q <= '0;
      inst_q     <= '0;
    end else if (rdy) begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rw_q       <= rw_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      len_q      <= len_nxt;
      sent       <= sent_nxt;
      got        <= got_nxt;
      rd_pipe    <= pipe_nxt;
      buf_q      <= buf_nxt;
      mem_a_q    <= mem_a_nxt;
      dout_q     <= dout_nxt;
      wr_q       <= wr_nxt;
      ok_lsb_q   <= ok_lsb_nxt;
      ok_if_q    <= ok_if_nxt;
      data_lsb_q <= data_lsb_nxt;
      inst_q     <= inst_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rw_nxt       = rw_q;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    len_nxt      = len_q;
    sent_nxt     = sent;
    got_nxt      = got;
    pipe_nxt     = rd_pipe;
    buf_nxt      = buf_q;
    mem_a_nxt    = mem_a_q;
    dout_nxt     = dout_q;
    wr_nxt       = 1'b0;
    ok_lsb_nxt   = 1'b0;
    ok_if_nxt    = 1'b0;
    data_lsb_nxt = data_lsb_q;
    inst_nxt     = inst_q;

    byte_addr  = addr_q + ADDR_WIDTH'(sent);
    store_byte = 8'(data_q >> {sent, 3'b000});
    // buf_q is cleared at accept, so OR-ing the new lane in is enough.
    read_word  = buf_q | (DATA_WIDTH'(bus.mem_din) << {got, 3'b000});

    case (state)
      ST_IDLE: begin
        if (bus.enable_from_lsb || (bus.enable_from_if && !bus.mispredict)) begin
          if (bus.enable_from_lsb) begin
            owner_nxt = OWN_LSB;
            rw_nxt    = bus.read_or_write_from_lsb;
            addr_nxt  = bus.addr_from_lsb;
            data_nxt  = bus.data_from_lsb;
            len_nxt   = width_to_len(bus.width_from_lsb);
          end else begin
            owner_nxt = OWN_IF;
            rw_nxt    = 1'b0;
            addr_nxt  = bus.addr_from_if;
            data_nxt  = '0;
            len_nxt   = 3'd4;
          end
          sent_nxt = '0;
          got_nxt  = '0;
          pipe_nxt = '0;
          buf_nxt  = '0;
          if (!rw_nxt) begin
            mem_a_nxt = addr_nxt;
            sent_nxt  = 3'd1;
            pipe_nxt  = 2'b01;
            state_nxt = ST_READ;
          end else begin
            state_nxt = ST_WRITE;
            if (!(is_io(addr_nxt) && bus.io_buffer_full)) begin
              mem_a_nxt = addr_nxt;
              dout_nxt  = data_nxt[7:0];
              wr_nxt    = 1'b1;
              sent_nxt  = 3'd1;
            end
          end
        end
      end

      ST_READ: begin
        pipe_nxt = {rd_pipe[0], 1'b0};
        if (owner == OWN_IF && bus.mispredict) begin
          state_nxt = ST_IDLE;
          sent_nxt  = '0;
          got_nxt   = '0;
          pipe_nxt  = '0;
          buf_nxt   = '0;
        end else begin
          if (sent < len_q) begin
            mem_a_nxt   = byte_addr;
            sent_nxt    = sent + 3'd1;
            pipe_nxt[0] = 1'b1;
          end
          if (rd_pipe[1]) begin
            got_nxt = got + 3'd1;
            buf_nxt = read_word;
            if (got == len_q - 3'd1) begin
              state_nxt = ST_DONE;
              if (owner == OWN_LSB) begin
                ok_lsb_nxt   = 1'b1;
                data_lsb_nxt = read_word;
              end else begin
                ok_if_nxt = 1'b1;
                inst_nxt  = read_word;
              end
            end
          end
        end
      end

      ST_WRITE: begin
        if (sent < len_q) begin
          if (!(is_io(byte_addr) && bus.io_buffer_full)) begin
            mem_a_nxt = byte_addr;
            dout_nxt  = store_byte;
            wr_nxt    = 1'b1;
            sent_nxt  = sent + 3'd1;
          end
        end else begin
          state_nxt  = ST_DONE;
          ok_lsb_nxt = (owner == OWN_LSB);
          ok_if_nxt  = (owner == OWN_IF);
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        sent_nxt  = '0;
        got_nxt   = '0;
        pipe_nxt  = '0;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = dout_q;
  assign bus.mem_wr      = wr_q;
  assign bus.ok_to_lsb   = ok_lsb_q;
  assign bus.ok_to_if    = ok_if_q;
  assign bus.data_to_lsb = data_lsb_q;
  assign bus.inst_to_if  = inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scenario tasks for mem_ctrl with a registered byte RAM model
// and scoreboard queues of expected read words and write bytes.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] exp_rd_q [$];
  logic [39:0] exp_wr_q [$];
  logic [39:0] obs_wr_q [$];
  int          ok_lsb_cnt = 0;
  int          ok_if_cnt  = 0;

  // Registered RAM: samples mem_a at an edge, returns the byte after it.
  always @(posedge clk) begin
    if (rdy) begin
      bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
      if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end
  end

  always @(negedge clk) begin
    if (rdy && bus.mem_wr) obs_wr_q.push_back({bus.mem_a, bus.mem_dout});
    if (bus.ok_to_lsb) ok_lsb_cnt++;
    if (bus.ok_to_if)  ok_if_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ram[a + 32'(i)] = w[8*i +: 8];
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] w);
    bus.read_or_write_from_lsb = wr;
    bus.addr_from_lsb          = a;
    bus.data_from_lsb          = d;
    bus.width_from_lsb         = w;
    bus.enable_from_lsb        = 1'b1;
  endtask

  task automatic wait_ok(input bit want_if, input int max, output int edges,
                         output bit seen, output logic [31:0] data);
    edges = 0;
    seen  = 1'b0;
    data  = '0;
    while (!seen && edges < max) begin
      tick();
      edges++;
      if (want_if ? bus.ok_to_if : bus.ok_to_lsb) begin
        seen = 1'b1;
        data = want_if ? bus.inst_to_if : bus.data_to_lsb;
      end
    end
  endtask

  function automatic logic [106:0] all_outs();
    return {bus.mem_a, bus.mem_dout, bus.mem_wr, bus.ok_to_lsb, bus.ok_to_if,
            bus.data_to_lsb, bus.inst_to_if};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    n_cmp++;
    if (dut.state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_state got %0d want %0d", dut.state, ST_IDLE);
    end
  endtask

  task automatic test_lw(input logic [2:0] w, input string tag);
    int e; bit s; logic [31:0] d; logic [31:0] ex;
    put_word(32'h100, 32'h44332211);
    exp_rd_q.push_back(32'h44332211);
    tick();
    lsb_req(1'b0, 32'h100, 32'h0, w);
    wait_ok(1'b0, 20, e, s, d);
    bus.enable_from_lsb = 1'b0;
    ex = exp_rd_q.pop_front();
    n_cmp++;
    if (!s || e !== 6) begin
      n_bad++;
      $display("FAIL %s_latency got seen=%0d edges=%0d want seen=1 edges=6", tag, s, e);
    end
    n_cmp++;
    if (d !== ex) begin
      n_bad++;
      $display("FAIL %s_data got %h want %h", tag, d, ex);
    end
    tick();
    n_cmp++;
    if (bus.ok_to_lsb !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ok_pulse got ok=%b one cycle later want 0", tag, bus.ok_to_lsb);
    end
  endtask

  task automatic test_sh();
    int e; bit s; logic [31:0] d; logic [39:0] ex;
    obs_wr_q.delete();
    exp_wr_q.push_back({32'h200, 8'hDD});
    exp_wr_q.push_back({32'h201, 8'hCC});
    tick();
    lsb_req(1'b1, 32'h200, 32'hAABBCCDD, 3'd2);
    wait_ok(1'b0, 20, e, s, d);
    bus.enable_from_lsb = 1'b0;
    n_cmp++;
    if (!s || e !== 3 || bus.mem_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL sh_done got seen=%0d edges=%0d mem_wr=%b want 1/3/0", s, e, bus.mem_wr);
    end
    repeat (4) tick();
    n_cmp++;
    if (obs_wr_q.size() !== 2) begin
      n_bad++;
      $display("FAIL sh_write_count got %0d want 2", obs_wr_q.size());
    end
    while (exp_wr_q.size() > 0) begin
      ex = exp_wr_q.pop_front();
      n_cmp++;
      if (obs_wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL sh_write got none want %h", ex);
      end else if (obs_wr_q[0] !== ex) begin
        n_bad++;
        $display("FAIL sh_write got %h want %h", obs_wr_q[0], ex);
        void'(obs_wr_q.pop_front());
      end else begin
        void'(obs_wr_q.pop_front());
      end
    end
  endtask

  task automatic test_priority();
    int e; bit s; logic [31:0] d; logic [31:0] ex;
    put_word(32'h300, 32'h7755339A);
    put_word(32'h400, 32'hCAFEF00D);
    exp_rd_q.push_back(32'h0000009A);
    exp_rd_q.push_back(32'hCAFEF00D);
    tick();
    lsb_req(1'b0, 32'h300, 32'h0, 3'd1);
    bus.addr_from_if   = 32'h400;
    bus.enable_from_if = 1'b1;
    e = 0;
    while (!bus.ok_to_lsb && !bus.ok_to_if && e < 20) begin
      tick();
      e++;
    end
    ex = exp_rd_q.pop_front();
    n_cmp++;
    if (bus.ok_to_lsb !== 1'b1 || bus.ok_to_if !== 1'b0 || e !== 3) begin
      n_bad++;
      $display("FAIL prio_first got ok_lsb=%b ok_if=%b edges=%0d want 1/0/3",
               bus.ok_to_lsb, bus.ok_to_if, e);
    end
    n_cmp++;
    if (bus.data_to_lsb !== ex) begin
      n_bad++;
      $display("FAIL prio_lb_data got %h want %h", bus.data_to_lsb, ex);
    end
    bus.enable_from_lsb = 1'b0;
    wait_ok(1'b1, 20, e, s, d);
    bus.enable_from_if = 1'b0;
    ex = exp_rd_q.pop_front();
    n_cmp++;
    if (!s || d !== ex) begin
      n_bad++;
      $display("FAIL prio_fetch got seen=%0d inst=%h want 1/%h", s, d, ex);
    end
  endtask

  task automatic test_mispredict();
    int e; bit s; logic [31:0] d; logic [31:0] ex; int base;
    put_word(32'h1000, 32'h01020304);
    put_word(32'h2000, 32'hDEADBEEF);
    repeat (2) tick();
    base = ok_if_cnt;
    bus.addr_from_if   = 32'h1000;
    bus.enable_from_if = 1'b1;
    repeat (3) tick();
    bus.mispredict     = 1'b1;
    bus.enable_from_if = 1'b0;
    tick();
    n_cmp++;
    if (dut.state !== ST_IDLE || bus.ok_to_if !== 1'b0) begin
      n_bad++;
      $display("FAIL mispredict_abort got state=%0d ok_if=%b want %0d/0",
               dut.state, bus.ok_to_if, ST_IDLE);
    end
    bus.mispredict     = 1'b0;
    bus.addr_from_if   = 32'h2000;
    bus.enable_from_if = 1'b1;
    exp_rd_q.push_back(32'hDEADBEEF);
    wait_ok(1'b1, 20, e, s, d);
    bus.enable_from_if = 1'b0;
    ex = exp_rd_q.pop_front();
    n_cmp++;
    if (!s || e !== 6 || d !== ex) begin
      n_bad++;
      $display("FAIL refetch got seen=%0d edges=%0d inst=%h want 1/6/%h", s, e, d, ex);
    end
    tick();
    n_cmp++;
    if (ok_if_cnt - base !== 1) begin
      n_bad++;
      $display("FAIL mispredict_ok_count got %0d want 1", ok_if_cnt - base);
    end
  endtask

  task automatic test_io();
    int stall_bad; logic [39:0] ex;
    obs_wr_q.delete();
    exp_wr_q.push_back({32'h30000, 8'h5A});
    bus.io_buffer_full = 1'b1;
    tick();
    lsb_req(1'b1, 32'h30000, 32'h1234565A, 3'd1);
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_wr !== 1'b0 || bus.ok_to_lsb !== 1'b0) stall_bad++;
    end
    n_cmp++;
    if (stall_bad != 0) begin
      n_bad++;
      $display("FAIL io_stall got %0d stalled cycles with activity want 0", stall_bad);
    end
    bus.io_buffer_full = 1'b0;
    tick();
    n_cmp++;
    if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h30000 || bus.mem_dout !== 8'h5A) begin
      n_bad++;
      $display("FAIL io_write got wr=%b a=%h d=%h want 1/00030000/5a",
               bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    tick();
    bus.enable_from_lsb = 1'b0;
    n_cmp++;
    if (bus.ok_to_lsb !== 1'b1 || bus.mem_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL io_ok got ok=%b wr=%b want 1/0", bus.ok_to_lsb, bus.mem_wr);
    end
    repeat (2) tick();
    ex = exp_wr_q.pop_front();
    n_cmp++;
    if (obs_wr_q.size() !== 1 || obs_wr_q[0] !== ex) begin
      n_bad++;
      $display("FAIL io_write_log got n=%0d first=%h want 1/%h",
               obs_wr_q.size(), (obs_wr_q.size() > 0) ? obs_wr_q[0] : 40'h0, ex);
    end
  endtask

  task automatic test_reset_mid();
    int e; bit s; logic [31:0] d; logic [31:0] ex; int base;
    put_word(32'h104, 32'h0BADF00D);
    tick();
    base = ok_lsb_cnt;
    lsb_req(1'b0, 32'h100, 32'h0, 3'd4);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs got %h want 0", all_outs());
    end
    rst = 1'b0;
    bus.enable_from_lsb = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if (ok_lsb_cnt !== base) begin
      n_bad++;
      $display("FAIL midreset_no_ok got %0d pulses want 0", ok_lsb_cnt - base);
    end
    exp_rd_q.push_back(32'h0BADF00D);
    lsb_req(1'b0, 32'h104, 32'h0, 3'd4);
    wait_ok(1'b0, 20, e, s, d);
    bus.enable_from_lsb = 1'b0;
    ex = exp_rd_q.pop_front();
    n_cmp++;
    if (!s || e !== 6 || d !== ex) begin
      n_bad++;
      $display("FAIL midreset_recover got seen=%0d edges=%0d data=%h want 1/6/%h", s, e, d, ex);
    end
  endtask

  task automatic test_rdy_stall();
    int e; bit s; logic [31:0] d; logic [31:0] ex;
    repeat (2) tick();
    exp_rd_q.push_back(32'h0BADF00D);
    lsb_req(1'b0, 32'h104, 32'h0, 3'd4);
    repeat (2) tick();
    rdy = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    wait_ok(1'b0, 20, e, s, d);
    bus.enable_from_lsb = 1'b0;
    ex = exp_rd_q.pop_front();
    n_cmp++;
    if (!s || e !== 4 || d !== ex) begin
      n_bad++;
      $display("FAIL rdy_stall got seen=%0d edges=%0d data=%h want 1/4/%h", s, e, d, ex);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.enable_from_lsb        = 1'b0;
    bus.read_or_write_from_lsb = 1'b0;
    bus.addr_from_lsb          = '0;
    bus.data_from_lsb          = '0;
    bus.width_from_lsb         = 3'd4;
    bus.enable_from_if         = 1'b0;
    bus.addr_from_if           = '0;
    bus.mispredict             = 1'b0;
    bus.io_buffer_full         = 1'b0;

    test_reset();
    test_lw(3'd4, "lw");
    test_lw(3'd3, "lw_width3");
    test_sh();
    test_priority();
    test_mispredict();
    test_io();
    test_reset_mid();
    test_rdy_stall();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
